// File: rtl/apb_slave_pkg.sv
// Shared types and constants for the APB wait-state completer.
package apb_slave_pkg;

  localparam int unsigned APB_ADDR_W = 8;
  localparam int unsigned APB_DATA_W = 8;
  localparam int unsigned WCNT_W     = 4;

  localparam logic [APB_DATA_W-1:0] APB_PRDATA_DFLT = 8'h00;

  typedef enum logic {
    IDLE,
    ACCESS
  } apb_state_e;

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
    return addr < depth;
  endfunction

endpackage

// File: rtl/apb_slave_regfile.sv
// Byte register array: async clear, one synchronous write port, one combinational read port.
module apb_slave_regfile #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned MEM_DEPTH = 64
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [MEM_DEPTH];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        if (i_we && (i_waddr == ADDR_W'(i))) begin
          r_mem[i] <= i_wdata;
        end
      end
    end
  end

  // Address decode as a compare per word so out-of-range addresses never index the array.
  always_comb begin
    o_rdata = '0;
    for (int i = 0; i < int'(MEM_DEPTH); i++) begin
      if (i_raddr == ADDR_W'(i)) begin
        o_rdata = r_mem[i];
      end
    end
  end

endmodule

// File: rtl/apb_wait_slave.sv
// APB3 completer with WAIT_CYCLES wait states over a byte register file.
// Define APB_WAIT_SLAVE_ERR_EN to report out-of-range accesses on PSLVERR.
module apb_wait_slave
  import apb_slave_pkg::*;
#(
  parameter int unsigned ADDR_W      = APB_ADDR_W,
  parameter int unsigned DATA_W      = APB_DATA_W,
  parameter int unsigned MEM_DEPTH   = 64,
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              PSEL,
  input  logic              PENABLE,
  input  logic              PWRITE,
  input  logic [ADDR_W-1:0] PADDR,
  input  logic [DATA_W-1:0] PWDATA,
  output logic [DATA_W-1:0] PRDATA,
  output logic              PREADY,
  output logic              PSLVERR
);

  apb_state_e        r_state;
  logic [WCNT_W-1:0] r_wcnt;
  logic [ADDR_W-1:0] r_addr;
  logic              r_write;

  logic              w_ready;
  logic              w_complete;
  logic              w_in_range;
  logic              w_we;
  logic [DATA_W-1:0] w_rdata;

  assign w_ready    = (r_state == ACCESS) && (r_wcnt == '0);
  assign w_complete = w_ready && PSEL && PENABLE;
  assign w_in_range = addr_in_range(32'(r_addr), MEM_DEPTH);
  assign w_we       = w_complete && r_write && w_in_range;

  // Address and direction are latched at setup; PWDATA is taken live on the completing edge.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (PSEL && !PENABLE) begin
            r_state <= ACCESS;
            r_wcnt  <= WCNT_W'(WAIT_CYCLES);
            r_addr  <= PADDR;
            r_write <= PWRITE;
          end
        end
        ACCESS: begin
          if (!PSEL) begin
            r_state <= IDLE;
            r_wcnt  <= '0;
          end else if (PENABLE) begin
            if (r_wcnt != '0) begin
              r_wcnt <= r_wcnt - 1'b1;
            end else begin
              r_state <= IDLE;
            end
          end
        end
        default: begin
          r_state <= IDLE;
          r_wcnt  <= '0;
        end
      endcase
    end
  end

  apb_slave_regfile #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MEM_DEPTH (MEM_DEPTH)
  ) u_regfile (
    .i_clk   (PCLK),
    .i_rst_n (PRESETn),
    .i_we    (w_we),
    .i_waddr (r_addr),
    .i_wdata (PWDATA),
    .i_raddr (r_addr),
    .o_rdata (w_rdata)
  );

  assign PREADY = w_ready;
  assign PRDATA = (w_ready && !r_write && w_in_range) ? w_rdata : DATA_W'(APB_PRDATA_DFLT);

`ifdef APB_WAIT_SLAVE_ERR_EN
  assign PSLVERR = w_ready && !w_in_range;
`else
  assign PSLVERR = 1'b0;
`endif

endmodule

// File: tb/tb_apb_wait_slave.sv
// Scoreboard bench for apb_wait_slave: one instance with 2 wait states, one with none.
module tb_apb_wait_slave;

`ifdef APB_WAIT_SLAVE_ERR_EN
  localparam logic ERR_EN = 1'b1;
`else
  localparam logic ERR_EN = 1'b0;
`endif

  typedef struct {
    string      name;
    logic [7:0] rdata;
    logic       err;
    int         cyc;
  } res_t;

  logic       clk;
  logic       rst_n;
  logic       psel2;
  logic       psel0;
  logic       penable;
  logic       pwrite;
  logic [7:0] paddr;
  logic [7:0] pwdata;
  logic [7:0] prdata2;
  logic [7:0] prdata0;
  logic       pready2;
  logic       pready0;
  logic       pslverr2;
  logic       pslverr0;

  int n_checks = 0;
  int n_fail   = 0;

  res_t exp_q[$];
  res_t obs_q[$];

  apb_wait_slave #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .MEM_DEPTH   (64),
    .WAIT_CYCLES (2)
  ) u_dut2 (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .PSEL    (psel2),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata2),
    .PREADY  (pready2),
    .PSLVERR (pslverr2)
  );

  apb_wait_slave #(
    .ADDR_W      (8),
    .DATA_W      (8),
    .MEM_DEPTH   (64),
    .WAIT_CYCLES (0)
  ) u_dut0 (
    .PCLK    (clk),
    .PRESETn (rst_n),
    .PSEL    (psel0),
    .PENABLE (penable),
    .PWRITE  (pwrite),
    .PADDR   (paddr),
    .PWDATA  (pwdata),
    .PRDATA  (prdata0),
    .PREADY  (pready0),
    .PSLVERR (pslverr0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic rdy(input int which);
    return (which == 2) ? pready2 : pready0;
  endfunction

  // One transfer starting at the next negedge; records observed result at PREADY.
  task automatic xfer(input int which, input logic wr, input logic [7:0] addr,
                      input logic [7:0] addr_acc, input logic [7:0] data);
    res_t o;
    @(negedge clk);
    if (which == 2) psel2 = 1'b1; else psel0 = 1'b1;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = addr;
    pwdata  = ~data;
    o.cyc   = 1;
    @(negedge clk);
    penable = 1'b1;
    paddr   = addr_acc;
    pwdata  = data;
    o.cyc   = 2;
    #1;
    while (!rdy(which) && o.cyc < 40) begin
      @(negedge clk);
      o.cyc++;
      #1;
    end
    o.name  = "";
    o.rdata = (which == 2) ? prdata2 : prdata0;
    o.err   = (which == 2) ? pslverr2 : pslverr0;
    obs_q.push_back(o);
  endtask

  task automatic bus_idle();
    @(negedge clk);
    psel2   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
  endtask

  task automatic test_reset();
    res_t e;
    res_t o;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    n_checks += 4;
    if (pready2 !== 1'b0) begin n_fail++; $display("FAIL rst_pready2 got %b want 0", pready2); end
    if (pslverr2 !== 1'b0) begin n_fail++; $display("FAIL rst_pslverr2 got %b want 0", pslverr2); end
    if (prdata2 !== 8'h00) begin n_fail++; $display("FAIL rst_prdata2 got %h want 00", prdata2); end
    if (pready0 !== 1'b0) begin n_fail++; $display("FAIL rst_pready0 got %b want 0", pready0); end
    rst_n = 1'b1;

    exp_q.push_back('{"rst_wr05", 8'h00, 1'b0, 4});
    xfer(2, 1'b1, 8'h05, 8'h05, 8'h5A);
    // Read 0x05 and pull reset while the completing cycle is on the bus.
    @(negedge clk);
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h05;
    @(negedge clk);
    penable = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_checks += 2;
    if (pready2 !== 1'b1) begin n_fail++; $display("FAIL pre_rst_pready got %b want 1", pready2); end
    if (prdata2 !== 8'h5A) begin n_fail++; $display("FAIL pre_rst_prdata got %h want 5a", prdata2); end
    #1;
    rst_n = 1'b0;
    #1;
    n_checks += 3;
    if (pready2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pready got %b want 0", pready2); end
    if (pslverr2 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_pslverr got %b want 0", pslverr2); end
    if (prdata2 !== 8'h00) begin n_fail++; $display("FAIL mid_rst_prdata got %h want 00", prdata2); end
    bus_idle();
    rst_n = 1'b1;

    exp_q.push_back('{"rst_rd05", 8'h00, 1'b0, 4});
    xfer(2, 1'b0, 8'h05, 8'h05, 8'h00);
    bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s no result", e.name); end
      else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s got rd=%h err=%b cyc=%0d want rd=%h err=%b cyc=%0d",
                   e.name, o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_write_read();
    res_t e;
    res_t o;
    exp_q.push_back('{"wr10", 8'h00, 1'b0, 4});
    xfer(2, 1'b1, 8'h10, 8'h10, 8'hA5);
    exp_q.push_back('{"rd10", 8'hA5, 1'b0, 4});
    xfer(2, 1'b0, 8'h10, 8'h10, 8'h00);
    bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s no result", e.name); end
      else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s got rd=%h err=%b cyc=%0d want rd=%h err=%b cyc=%0d",
                   e.name, o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    res_t e;
    res_t o;
    exp_q.push_back('{"z_wr00", 8'h00, 1'b0, 2});
    xfer(0, 1'b1, 8'h00, 8'h00, 8'h11);
    exp_q.push_back('{"z_wr01", 8'h00, 1'b0, 2});
    xfer(0, 1'b1, 8'h01, 8'h01, 8'h22);
    exp_q.push_back('{"z_rd00", 8'h11, 1'b0, 2});
    xfer(0, 1'b0, 8'h00, 8'h00, 8'h00);
    exp_q.push_back('{"z_rd01", 8'h22, 1'b0, 2});
    xfer(0, 1'b0, 8'h01, 8'h01, 8'h00);
    bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s no result", e.name); end
      else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s got rd=%h err=%b cyc=%0d want rd=%h err=%b cyc=%0d",
                   e.name, o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    res_t e;
    res_t o;
    exp_q.push_back('{"oor_wr3f", 8'h00, 1'b0, 4});
    xfer(2, 1'b1, 8'h3F, 8'h3F, 8'h5C);
    exp_q.push_back('{"oor_wr40", 8'h00, ERR_EN, 4});
    xfer(2, 1'b1, 8'h40, 8'h40, 8'hFF);
    exp_q.push_back('{"oor_rd3f", 8'h5C, 1'b0, 4});
    xfer(2, 1'b0, 8'h3F, 8'h3F, 8'h00);
    exp_q.push_back('{"oor_rd40", 8'h00, ERR_EN, 4});
    xfer(2, 1'b0, 8'h40, 8'h40, 8'h00);
    bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s no result", e.name); end
      else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s got rd=%h err=%b cyc=%0d want rd=%h err=%b cyc=%0d",
                   e.name, o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_abort();
    res_t e;
    res_t o;
    @(negedge clk);
    psel2   = 1'b1;
    penable = 1'b0;
    pwrite  = 1'b1;
    paddr   = 8'h20;
    pwdata  = 8'h77;
    @(negedge clk);
    penable = 1'b1;
    @(negedge clk);
    psel2   = 1'b0;
    penable = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (pready2 !== 1'b0) begin n_fail++; $display("FAIL abort_pready got %b want 0", pready2); end
    exp_q.push_back('{"abort_rd20", 8'h00, 1'b0, 4});
    xfer(2, 1'b0, 8'h20, 8'h20, 8'h00);
    bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s no result", e.name); end
      else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s got rd=%h err=%b cyc=%0d want rd=%h err=%b cyc=%0d",
                   e.name, o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_addr_change();
    res_t e;
    res_t o;
    exp_q.push_back('{"ac_wr08", 8'h00, 1'b0, 4});
    xfer(2, 1'b1, 8'h08, 8'h09, 8'h3C);
    exp_q.push_back('{"ac_rd08", 8'h3C, 1'b0, 4});
    xfer(2, 1'b0, 8'h08, 8'h08, 8'h00);
    exp_q.push_back('{"ac_rd09", 8'h00, 1'b0, 4});
    xfer(2, 1'b0, 8'h09, 8'h09, 8'h00);
    bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s no result", e.name); end
      else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s got rd=%h err=%b cyc=%0d want rd=%h err=%b cyc=%0d",
                   e.name, o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  task automatic test_stray_enable();
    res_t e;
    res_t o;
    @(negedge clk);
    psel2   = 1'b1;
    penable = 1'b1;
    pwrite  = 1'b0;
    paddr   = 8'h10;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      n_checks++;
      if (pready2 !== 1'b0) begin
        n_fail++;
        $display("FAIL stray_pready[%0d] got %b want 0", i, pready2);
      end
    end
    bus_idle();
    exp_q.push_back('{"stray_rd10", 8'hA5, 1'b0, 4});
    xfer(2, 1'b0, 8'h10, 8'h10, 8'h00);
    bus_idle();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (obs_q.size() == 0) begin n_fail++; $display("FAIL %s no result", e.name); end
      else begin
        o = obs_q.pop_front();
        if (o.rdata !== e.rdata || o.err !== e.err || o.cyc != e.cyc) begin
          n_fail++;
          $display("FAIL %s got rd=%h err=%b cyc=%0d want rd=%h err=%b cyc=%0d",
                   e.name, o.rdata, o.err, o.cyc, e.rdata, e.err, e.cyc);
        end
      end
    end
  endtask

  initial begin
    rst_n   = 1'b0;
    psel2   = 1'b0;
    psel0   = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
    paddr   = 8'h00;
    pwdata  = 8'h00;
    test_reset();
    test_write_read();
    test_back_to_back();
    test_out_of_range();
    test_abort();
    test_addr_change();
    test_stray_enable();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
